// File: rtl/serial_word_accumulator.sv
// -----------------------------------------------------------------------------
// serial_word_accumulator
//
// Bit-serial adder of K parallel-loaded W-bit words. A job captures all K
// words at once. Each RUN cycle then takes one bit plane, which is the same
// bit of every word, starting at the LSB. The popcount of that plane is
// weighted by its bit position and added to an accumulator. After W planes
// the accumulator holds the exact K-word sum.
//
// In signed mode the MSB plane carries weight -2^(W-1). Its weighted
// popcount is therefore subtracted instead of added, and the result is the
// two's-complement sum.
//
// The result is SW = W + clog2(K) bits wide. That width holds any K-word
// sum in either mode, so the accumulator wraps only in intermediate
// signed steps, and modulo-2^SW arithmetic still lands on the exact result.
//
// Handshakes (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The producer must hold valid (and its data) until that edge.
//   ready may be asserted independently of valid.
//   On the input side, in_ready is high only in IDLE.
//   On the output side, out_valid is high only in DONE, and sum is stable
//   while out_valid is high.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high; clears every register
//   in_valid     a job is present on din / signed_mode
//   in_ready     block can accept a job (IDLE)
//   din          K words, word j at din[j*W +: W]
//   signed_mode  1 = words are two's complement; captured with din
//   enable       0 freezes RUN progress; ignored in IDLE and DONE
//   out_valid    sum is valid (DONE)
//   out_ready    consumer accepts sum; only acted on in DONE
//   sum          K-word sum, SW bits
//   busy         FSM is not in IDLE
// -----------------------------------------------------------------------------
module serial_word_accumulator #(
  parameter int W = 5,
  parameter int K = 4,
  localparam int SW = W + $clog2(K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W*K-1:0]  din,
  input  logic            signed_mode,
  input  logic            enable,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   sum,
  output logic            busy
);

  // Popcount of one plane ranges over 0..K.
  localparam int PCW = $clog2(K + 1);
  // Bit counter addresses planes 0..W-1.
  localparam int BW  = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [W*K-1:0]  words_q;
  logic [W*K-1:0]  words_shift;
  logic            signed_q;
  logic [BW-1:0]   bit_q;
  logic [SW-1:0]   acc_q;
  logic [SW-1:0]   sum_q;

  logic [PCW-1:0]  pc;
  logic [SW-1:0]   term;
  logic [SW-1:0]   acc_next;
  logic            last_plane;
  logic            accept;
  logic            step;

  // ---------------------------------------------------------------------------
  // Plane datapath
  // ---------------------------------------------------------------------------
  // The captured words shift right by one bit per processed plane.
  // Bit 0 of each word is therefore always the current plane.
  always_comb begin
    words_shift = '0;
    for (int j = 0; j < K; j++) begin
      words_shift[j*W +: W] = {1'b0, words_q[j*W+1 +: W-1]};
    end
  end

  always_comb begin
    pc = '0;
    for (int j = 0; j < K; j++) begin
      pc = pc + PCW'(words_q[j*W]);
    end
  end

  assign last_plane = (bit_q == BW'(W - 1));

  // The popcount is zero-extended to SW bits before the shift.
  // This keeps K*2^(W-1) representable.
  assign term = SW'(pc) << bit_q;

  // The MSB plane has negative weight for two's-complement words.
  assign acc_next = (signed_q && last_plane) ? (acc_q - term) : (acc_q + term);

  assign accept = (state_q == IDLE) && in_valid;
  assign step   = (state_q == RUN) && enable;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (enable && last_plane) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q  <= '0;
      signed_q <= 1'b0;
      bit_q    <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
    end else if (accept) begin
      words_q  <= din;
      signed_q <= signed_mode;
      bit_q    <= '0;
      acc_q    <= '0;
    end else if (step) begin
      words_q <= words_shift;
      acc_q   <= acc_next;
      if (last_plane) begin
        // The result is published on the same edge that enters DONE.
        sum_q <= acc_next;
      end else begin
        bit_q <= bit_q + BW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;

endmodule
